// File: rtl/wb_shared_port_arbiter.sv
// rtl/wb_shared_port_arbiter.sv - two-master round-robin arbiter onto one shared Wishbone slave
// Optional ARB_TIMEOUT_EN adds a busy watchdog that aborts a stalled owner with mX_err.
module wb_shared_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_core,
  input  logic                    rst_core,

  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  output logic [DATA_WIDTH-1:0]   m0_data_o,
  output logic                    m0_ack,
  output logic                    m0_err,

  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  output logic [DATA_WIDTH-1:0]   m1_data_o,
  output logic                    m1_ack,
  output logic                    m1_err,

  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_data_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_ack,

  output logic [1:0]              grant
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state;
  logic   owner;
  logic   last_served;
  logic   req0;
  logic   req1;
  logic   pick;
  logic   owner_cyc;
  logic   busy;

  assign req0      = m0_cyc & m0_stb;
  assign req1      = m1_cyc & m1_stb;
  // On contention the master that was not served last wins.
  assign pick      = (req0 & req1) ? ~last_served : req1;
  assign owner_cyc = owner ? m1_cyc : m0_cyc;
  assign busy      = (state == BUSY);

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_sel    = '0;
    s_addr   = '0;
    s_data_o = '0;
    if (busy) begin
      if (owner) begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_sel    = m1_sel;
        s_addr   = m1_addr;
        s_data_o = m1_data_i;
      end else begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_sel    = m0_sel;
        s_addr   = m0_addr;
        s_data_o = m0_data_i;
      end
    end
  end

  // An ack arriving while the owner has already released cyc is swallowed.
  assign m0_ack    = busy & ~owner & m0_cyc & s_ack;
  assign m1_ack    = busy &  owner & m1_cyc & s_ack;
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] tmo_cnt;
  logic [15:0] tmo_next;
  logic [1:0]  err_q;

  assign tmo_next = tmo_cnt + 16'd1;
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      grant       <= 2'b00;
      tmo_cnt     <= 16'd0;
      err_q       <= 2'b00;
    end else begin
      err_q <= 2'b00;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state   <= BUSY;
            owner   <= pick;
            grant   <= pick ? 2'b10 : 2'b01;
            tmo_cnt <= 16'd0;
          end
        end
        BUSY: begin
          if (!owner_cyc) begin
            state <= IDLE;
            grant <= 2'b00;
          end else if (s_ack) begin
            state       <= IDLE;
            grant       <= 2'b00;
            last_served <= owner;
          end else if (tmo_next == TMO_LIMIT) begin
            state        <= IDLE;
            grant        <= 2'b00;
            last_served  <= owner;
            err_q[owner] <= 1'b1;
            tmo_cnt      <= tmo_next;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      grant       <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state <= BUSY;
            owner <= pick;
            grant <= pick ? 2'b10 : 2'b01;
          end
        end
        BUSY: begin
          if (!owner_cyc) begin
            state <= IDLE;
            grant <= 2'b00;
          end else if (s_ack) begin
            state       <= IDLE;
            grant       <= 2'b00;
            last_served <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_wb_shared_port_arbiter.sv
// tb/tb_wb_shared_port_arbiter.sv - scoreboard bench for wb_shared_port_arbiter
module tb_wb_shared_port_arbiter;

  typedef struct {
    bit          id;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } txn_t;

  logic        clk_core = 1'b0;
  logic        rst_core = 1'b1;
  logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [3:0]  m0_sel = '0;
  logic [31:0] m0_addr = '0, m0_data_i = '0;
  logic [31:0] m0_data_o;
  logic        m0_ack, m0_err;
  logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [3:0]  m1_sel = '0;
  logic [31:0] m1_addr = '0, m1_data_i = '0;
  logic [31:0] m1_data_o;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_addr, s_data_o;
  logic [31:0] s_data_i = '0;
  logic        s_ack = 1'b0;
  logic [1:0]  grant;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   sb_en    = 1'b0;
  bit   m_last   = 1'b1;
  txn_t exp_q[$];

  always #5 clk_core = ~clk_core;

  wb_shared_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_addr(s_addr),
    .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack(s_ack), .grant(grant)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic txn_t new_txn(input bit id);
    txn_t t;
    t.id    = id;
    t.addr  = $urandom;
    t.we    = 1'($urandom_range(0, 1));
    t.sel   = 4'($urandom_range(1, 15));
    t.wdata = $urandom;
    t.rdata = $urandom;
    t.lat   = $urandom_range(0, 2);
    return t;
  endfunction

  task automatic drive(input bit id, input bit on, input txn_t t);
    if (id == 1'b0) begin
      m0_cyc = on; m0_stb = on; m0_we = on & t.we;
      m0_sel = on ? t.sel : 4'h0; m0_addr = on ? t.addr : 32'h0; m0_data_i = on ? t.wdata : 32'h0;
    end else begin
      m1_cyc = on; m1_stb = on; m1_we = on & t.we;
      m1_sel = on ? t.sel : 4'h0; m1_addr = on ? t.addr : 32'h0; m1_data_i = on ? t.wdata : 32'h0;
    end
  endtask

  task automatic master_txn(input txn_t t);
    bit ok = 1'b0;
    drive(t.id, 1'b1, t);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_core);
      if (t.id ? (m1_ack | m1_err) : (m0_ack | m0_err)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(t.id ? "m1_wait_ack" : "m0_wait_ack", 64'(0), 64'(1));
    @(posedge clk_core); #1;
    drive(t.id, 1'b0, t);
  endtask

  task automatic slave_serve(input txn_t t);
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_core);
      if (s_cyc && s_stb) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("slave_wait_stb", 64'(0), 64'(1));
      return;
    end
    repeat (t.lat) @(posedge clk_core);
    @(posedge clk_core); #1;
    s_ack = 1'b1; s_data_i = t.rdata;
    @(posedge clk_core); #1;
    s_ack = 1'b0; s_data_i = $urandom;
  endtask

  // Reference model: on contention the master other than the last one served goes first.
  task automatic run_round(input bit r0, input bit r1);
    txn_t t0, t1, first, second;
    int   n;
    t0 = new_txn(1'b0);
    t1 = new_txn(1'b1);
    second = t0;
    if (r0 && r1) begin
      if (m_last) begin first = t0; second = t1; end
      else begin first = t1; second = t0; end
      n = 2;
    end else begin
      first = r0 ? t0 : t1;
      n = 1;
    end
    exp_q.push_back(first);
    if (n == 2) exp_q.push_back(second);
    m_last = (n == 2) ? second.id : first.id;
    fork
      begin if (r0) master_txn(t0); end
      begin if (r1) master_txn(t1); end
      begin
        slave_serve(first);
        if (n == 2) slave_serve(second);
      end
    join
  endtask

  task automatic monitor();
    txn_t e;
    forever begin
      @(negedge clk_core);
      if (sb_en && !rst_core) begin
        if (s_cyc) begin
          if (exp_q.size() == 0) check("s_cyc_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_q[0];
            check("grant_owner", 64'(grant), 64'(e.id ? 2'b10 : 2'b01));
            check("s_addr", 64'(s_addr), 64'(e.addr));
            check("s_we", 64'(s_we), 64'(e.we));
            check("s_sel", 64'(s_sel), 64'(e.sel));
            check("s_data_o", 64'(s_data_o), 64'(e.wdata));
          end
        end
        if (m0_ack || m1_ack) begin
          if (exp_q.size() == 0) check("ack_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_q.pop_front();
            check("ack_master", 64'({m1_ack, m0_ack}), 64'(e.id ? 2'b10 : 2'b01));
            check("ack_data", 64'(e.id ? m1_data_o : m0_data_o), 64'(e.rdata));
            check("err_on_ack", 64'({m1_err, m0_err}), 64'(0));
          end
        end
      end
    end
  endtask

  task automatic wait_grant(input logic [1:0] want);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_core);
      if (grant == want) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_grant", 64'(grant), 64'(want));
  endtask

  initial begin
    txn_t d;
    fork monitor(); join_none

    // Reset with m0 already requesting: nothing may leak out.
    d.id = 1'b0; d.addr = 32'h100; d.we = 1'b0; d.sel = 4'hF; d.wdata = 32'h0; d.rdata = 32'h0; d.lat = 0;
    drive(1'b0, 1'b1, d);
    rst_core = 1'b1;
    repeat (2) @(posedge clk_core);
    @(negedge clk_core);
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_s_cyc", 64'(s_cyc), 64'(0));
    check("rst_s_stb", 64'(s_stb), 64'(0));
    check("rst_s_addr", 64'(s_addr), 64'(0));
    check("rst_s_sel", 64'(s_sel), 64'(0));
    check("rst_acks", 64'({m1_ack, m0_ack}), 64'(0));
    check("rst_errs", 64'({m1_err, m0_err}), 64'(0));
    @(posedge clk_core); #1;
    rst_core = 1'b0;
    @(negedge clk_core);
    check("req_cycle_grant", 64'(grant), 64'(0));
    @(negedge clk_core);
    check("m0_grant", 64'(grant), 64'(2'b01));
    check("m0_s_addr", 64'(s_addr), 64'(32'h100));
    check("m0_s_we", 64'(s_we), 64'(0));
    @(negedge clk_core);
    check("m0_ack_early", 64'(m0_ack), 64'(0));
    @(posedge clk_core); #1;
    s_ack = 1'b1; s_data_i = 32'hDEADBEEF;
    @(negedge clk_core);
    check("m0_ack", 64'(m0_ack), 64'(1));
    check("m0_data_o", 64'(m0_data_o), 64'(32'hDEADBEEF));
    check("m1_ack_quiet", 64'(m1_ack), 64'(0));
    @(posedge clk_core); #1;
    s_ack = 1'b0;
    drive(1'b0, 1'b0, d);
    @(negedge clk_core);
    check("grant_after_ack", 64'(grant), 64'(0));

    // Contention from reset, then random traffic.
    @(posedge clk_core); #1;
    rst_core = 1'b1;
    repeat (2) @(posedge clk_core); #1;
    rst_core = 1'b0;
    m_last = 1'b1;
    sb_en = 1'b1;
    repeat (3) run_round(1'b1, 1'b1);
    for (int r = 0; r < 24; r++) begin
      int pat;
      pat = $urandom_range(1, 3);
      run_round(pat[0], pat[1]);
    end
    sb_en = 1'b0;
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    // Owner drops cyc while the slave acks: ack suppressed, last_served untouched.
    d.addr = 32'h300; d.we = 1'b1; d.wdata = 32'hA5A5A5A5;
    drive(1'b0, 1'b1, d);
    wait_grant(2'b01);
    @(posedge clk_core); #1;
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b1;
    @(negedge clk_core);
    check("drop_m0_ack", 64'(m0_ack), 64'(0));
    @(posedge clk_core); #1;
    s_ack = 1'b0;
    drive(1'b0, 1'b0, d);
    @(negedge clk_core);
    check("drop_grant", 64'(grant), 64'(0));
    @(posedge clk_core); #1;
    sb_en = 1'b1;
    run_round(1'b1, 1'b1);
    sb_en = 1'b0;

    // Stalled slave.
    d.addr = 32'h500; d.we = 1'b0;
    drive(1'b0, 1'b1, d);
    wait_grant(2'b01);
    check("tmo_err_at_grant", 64'(m0_err), 64'(0));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_core);
      check("tmo_busy_grant", 64'(grant), 64'(2'b01));
      check("tmo_busy_err", 64'(m0_err), 64'(0));
    end
`ifdef ARB_TIMEOUT_EN
    @(posedge clk_core); #1;
    drive(1'b0, 1'b0, d);
    @(negedge clk_core);
    check("tmo_m0_err", 64'(m0_err), 64'(1));
    check("tmo_m1_err", 64'(m1_err), 64'(0));
    check("tmo_grant", 64'(grant), 64'(0));
    check("tmo_s_cyc", 64'(s_cyc), 64'(0));
    @(negedge clk_core);
    check("tmo_err_pulse", 64'(m0_err), 64'(0));
    check("tmo_grant_idle", 64'(grant), 64'(0));
`else
    repeat (4) begin
      @(negedge clk_core);
      check("notmo_grant", 64'(grant), 64'(2'b01));
      check("notmo_err", 64'(m0_err), 64'(0));
    end
    @(posedge clk_core); #1;
    s_ack = 1'b1;
    @(negedge clk_core);
    check("notmo_ack", 64'(m0_ack), 64'(1));
    @(posedge clk_core); #1;
    s_ack = 1'b0;
    drive(1'b0, 1'b0, d);
    @(negedge clk_core);
    check("notmo_grant_idle", 64'(grant), 64'(0));
`endif
    m_last = 1'b0;
    @(posedge clk_core); #1;
    sb_en = 1'b1;
    run_round(1'b1, 1'b1);
    sb_en = 1'b0;

    // Reset in the middle of an m1 transaction.
    d.id = 1'b1; d.addr = 32'h400; d.we = 1'b1; d.wdata = 32'h0BADF00D;
    drive(1'b1, 1'b1, d);
    wait_grant(2'b10);
    @(posedge clk_core); #1;
    rst_core = 1'b1;
    @(posedge clk_core); #1;
    drive(1'b1, 1'b0, d);
    @(negedge clk_core);
    check("rstmid_grant", 64'(grant), 64'(0));
    check("rstmid_s_cyc", 64'(s_cyc), 64'(0));
    check("rstmid_m1_ack", 64'(m1_ack), 64'(0));
    check("rstmid_m1_err", 64'(m1_err), 64'(0));
    @(posedge clk_core); #1;
    rst_core = 1'b0;
    m_last = 1'b1;
    @(negedge clk_core);
    check("rstmid_idle", 64'(grant), 64'(0));
    @(posedge clk_core); #1;
    sb_en = 1'b1;
    run_round(1'b1, 1'b1);
    run_round(1'b0, 1'b1);
    sb_en = 1'b0;
    check("final_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_shared_port_arbiter.md
WB_SHARED_PORT_ARBITER -- requirements
Module: wb_shared_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, the address width of the masters and the slave.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the data width, a multiple of 8.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the number of busy cycles without ack before abort (range 1..65535).
REQ-004 clk_core  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_core  input  1  reset, synchronous, active-high.
REQ-006 mX_cyc, X in {0,1}  input  1  master X transaction active.
REQ-007 mX_stb  input  1  master X request strobe.
REQ-008 mX_we  input  1  master X write (1) / read (0).
REQ-009 mX_sel  input  DATA_WIDTH/8  master X byte selects.
REQ-010 mX_addr  input  ADDR_WIDTH  master X address.
REQ-011 mX_data_i  input  DATA_WIDTH  master X write data.
REQ-012 mX_data_o  output  DATA_WIDTH  read data to master X.
REQ-013 mX_ack  output  1  transaction complete, to master X.
REQ-014 mX_err  output  1  transaction aborted, to master X.
REQ-015 s_cyc, s_stb, s_we  output  1 each  shared slave controls.
REQ-016 s_sel  output  DATA_WIDTH/8; s_addr  output  ADDR_WIDTH; s_data_o  output  DATA_WIDTH  shared slave request.
REQ-017 s_data_i  input  DATA_WIDTH; s_ack  input  1  shared slave response.
REQ-018 grant  output  2  one-hot current owner (bit X = master X), 00 when idle.

Function
REQ-019 The arbiter SHALL implement states IDLE and BUSY plus a registered owner bit and a last_served bit.
REQ-020 A master SHALL be requesting when mX_cyc and mX_stb are both 1.
REQ-021 In IDLE with exactly one requester, the arbiter SHALL enter BUSY with that owner on the next edge.
REQ-022 In IDLE with both requesting, the owner SHALL be the master not equal to last_served (round-robin).
REQ-023 In BUSY, s_cyc/s_stb/s_we/s_sel/s_addr/s_data_o SHALL combinationally equal the owner's signals; in IDLE all slave outputs SHALL be 0.
REQ-024 mX_ack SHALL equal s_ack only when X is owner in BUSY, else 0; mX_data_o SHALL equal s_data_i for both masters.
REQ-025 On s_ack while BUSY, the arbiter SHALL return to IDLE on the same edge and set last_served to the owner; new grant earliest one cycle after ack.
REQ-026 If the owner deasserts mX_cyc in BUSY, the arbiter SHALL return to IDLE next edge without updating last_served; an s_ack in that cycle SHALL NOT be forwarded.
REQ-027 A request from the non-owner during BUSY SHALL be held off (no ack, no err) until granted.
REQ-028 grant SHALL reflect state/owner registers, no combinational path from inputs.

Reset
REQ-029 On rst_core: state IDLE, owner 0, last_served 1 (master 0 wins first contention), timeout counter 0, grant 00, all slave outputs 0, mX_ack 0, mX_err 0.
REQ-030 rst_core asserted mid-transaction SHALL abort it silently: no ack or err issued, slave outputs 0 from the next cycle.

Configuration
REQ-031 Macro ARB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entering BUSY, increment each BUSY cycle without s_ack; when it reaches TIMEOUT_CYCLES the owner's mX_err SHALL pulse for one cycle, s_cyc/s_stb drop, state returns IDLE, last_served set to owner.
REQ-032 Macro ARB_TIMEOUT_EN undefined: no counter SHALL be built, mX_err SHALL be tied 0, BUSY persists until s_ack or owner drops cyc.

Verification
REQ-033 Reset, then m0 read addr 0x100, s_ack after 2 cycles with s_data_i 0xDEADBEEF -> grant 01 one cycle after request, m0_ack one cycle, m0_data_o 0xDEADBEEF, m1_ack 0.
REQ-034 Both masters request in the same cycle after reset -> m0 served first, m1 granted the cycle after m0_ack; repeat both -> m1 is not starved, grants alternate 01,10,01.
REQ-035 m1 write 0x200 data 0x12345678 sel 1111 while m0 owns -> s_addr stays m0's until m0_ack, then s_addr 0x200, s_we 1, s_data_o 0x12345678.
REQ-036 m0 drops cyc in BUSY with s_ack pulsed same cycle -> m0_ack 0, grant 00 next cycle.
REQ-037 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES 4, slave never acks -> m0_err pulses once exactly 4 BUSY cycles after grant, grant 00 afterwards; undefined -> grant stays 01, err 0.
REQ-038 rst_core asserted during m1 BUSY -> grant 00, s_cyc 0 next cycle, no m1_ack or m1_err.
